// File: rtl/sobel_pkg.sv
// Shared types and default dimensions for the Sobel window sequencer.
package sobel_pkg;

  localparam int DEF_IMG_W = 8;
  localparam int DEF_IMG_H = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    READ,
    SHIFT,
    CALC,
    WRITE,
    NEXT,
    DONE
  } seq_state_t;

endpackage

// File: rtl/sobel_addr_gen.sv
// Raster counters (r, c, k, rbase) and read/write address generation.
// The FSM drives one-cycle advance strobes; this block only counts.
module sobel_addr_gen #(
  parameter int IMG_W    = 8,
  parameter int IMG_H    = 8,
  parameter int ADDR_W   = 6,
  parameter int OUT_BASE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              init,
  input  logic              k_inc,
  input  logic              k_clr,
  input  logic              c_inc,
  input  logic              row_inc,
  input  logic              wr_sel,
  output logic              k_last,
  output logic              c_last,
  output logic              c_ge2,
  output logic              r_last,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_addr
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0]     C_LAST    = CW'(IMG_W - 1);
  localparam logic [RW-1:0]     R_LAST    = RW'(IMG_H - 2);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ROW_STEP2 = ADDR_W'(2 * IMG_W);
  // r*IMG_W == rbase + IMG_W, so the write address needs no multiplier.
  localparam logic [ADDR_W-1:0] OUT_OFS   = ADDR_W'(OUT_BASE + IMG_W - 1);

  logic [RW-1:0]     r;
  logic [CW-1:0]     c;
  logic [1:0]        k;
  logic [ADDR_W-1:0] rbase;
  logic [ADDR_W-1:0] koff;

  // Counter update: abort clear, frame init, then individual advances.
  // NOTE: non-blocking assignments keep every counter sampling pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r     <= '0;
      c     <= '0;
      k     <= '0;
      rbase <= '0;
    end else if (clr) begin
      r     <= '0;
      c     <= '0;
      k     <= '0;
      rbase <= '0;
    end else if (init) begin
      r     <= RW'(1);
      c     <= '0;
      k     <= '0;
      rbase <= '0;
    end else begin
      if (k_inc)   k <= k + 2'd1;
      if (k_clr)   k <= '0;
      if (c_inc)   c <= c + CW'(1);
      if (row_inc) begin
        c     <= '0;
        r     <= r + RW'(1);
        rbase <= rbase + ROW_STEP;
      end
    end
  end

  // Row offset within the 3-row band, selected from constants.
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    koff = '0;
    case (k)
      2'd1:    koff = ROW_STEP;
      2'd2:    koff = ROW_STEP2;
      default: koff = '0;
    endcase
  end

  assign rd_addr = rbase + koff + ADDR_W'(c);
  // Only meaningful while writing; held at zero otherwise so idle outputs read 0.
  assign wr_addr = wr_sel ? (rbase + OUT_OFS + ADDR_W'(c)) : '0;

  assign k_last = (k == 2'd2);
  assign c_last = (c == C_LAST);
  assign c_ge2  = (c >= CW'(2));
  assign r_last = (r == R_LAST);

endmodule

// File: rtl/sobel_window_sequencer.sv
// Frame sequencer for the Sobel datapath: raster walk over 3x3 windows,
// issuing read/shift/calc/write requests and waiting on each done strobe.
module sobel_window_sequencer
  import sobel_pkg::*;
#(
  parameter int IMG_W    = DEF_IMG_W,
  parameter int IMG_H    = DEF_IMG_H,
  parameter int ADDR_W   = $clog2(IMG_W * IMG_H),
  parameter int OUT_BASE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_done,
  output logic              line_clr,
  output logic              shift_req,
  input  logic              shift_done,
  output logic              calc_req,
  input  logic              calc_done,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_done,
  output logic              busy,
  output logic              done
);

  if (IMG_W < 3) begin : g_bad_w
    $error("sobel_window_sequencer: IMG_W must be >= 3");
  end
  if (IMG_H < 3) begin : g_bad_h
    $error("sobel_window_sequencer: IMG_H must be >= 3");
  end

  seq_state_t state, state_nx;

  logic ag_init, k_inc, k_clr, c_inc, row_inc;
  logic k_last, c_last, c_ge2, r_last;

  sobel_addr_gen #(
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H),
    .ADDR_W  (ADDR_W),
    .OUT_BASE(OUT_BASE)
  ) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .clr    (abort),
    .init   (ag_init),
    .k_inc  (k_inc),
    .k_clr  (k_clr),
    .c_inc  (c_inc),
    .row_inc(row_inc),
    .wr_sel (wr_req),
    .k_last (k_last),
    .c_last (c_last),
    .c_ge2  (c_ge2),
    .r_last (r_last),
    .rd_addr(rd_addr),
    .wr_addr(wr_addr)
  );

  // State register; asynchronous reset drops every request between edges.
  // NOTE: rst sits in the sensitivity list so the outputs decoded from state clear at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state: abort wins over any done strobe arriving in the same cycle.
  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nx = CLR;
        CLR:     state_nx = READ;
        READ:    if (rd_done && k_last) state_nx = SHIFT;
        SHIFT:   if (shift_done) state_nx = c_ge2 ? CALC : NEXT;
        CALC:    if (calc_done) state_nx = WRITE;
        WRITE:   if (wr_done) state_nx = NEXT;
        NEXT: begin
          if (!c_last)      state_nx = READ;
          else if (!r_last) state_nx = CLR;
          else              state_nx = DONE;
        end
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Outputs and counter strobes decoded from the current state.
  always_comb begin
    rd_req    = (state == READ);
    line_clr  = (state == CLR);
    shift_req = (state == SHIFT);
    calc_req  = (state == CALC);
    wr_req    = (state == WRITE);
    done      = (state == DONE);
    busy      = (state != IDLE) && (state != DONE);

    ag_init = !abort && (state == IDLE) && start;
    k_inc   = !abort && (state == READ) && rd_done && !k_last;
    k_clr   = !abort && (state == READ) && rd_done &&  k_last;
    c_inc   = !abort && (state == NEXT) && !c_last;
    row_inc = !abort && (state == NEXT) &&  c_last && !r_last;
  end

endmodule

// File: tb/tb_sobel_window_sequencer.sv
// Directed bench for sobel_window_sequencer on a 4x4 image.
module tb_sobel_window_sequencer;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst, start, abort;
  logic rd_req, line_clr, shift_req, calc_req, wr_req, busy, done;
  logic rd_done, shift_done, calc_done, wr_done;
  logic [AW-1:0] rd_addr, wr_addr;

  sobel_window_sequencer #(
    .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .OUT_BASE(0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_done(rd_done),
    .line_clr(line_clr),
    .shift_req(shift_req), .shift_done(shift_done),
    .calc_req(calc_req), .calc_done(calc_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_done(wr_done),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Responders: done after lat_* cycles of request, plus spurious overrides.
  int lat_rd = 0, lat_sh = 0, lat_ca = 0, lat_wr = 0;
  int cnt_rd = 0, cnt_sh = 0, cnt_ca = 0, cnt_wr = 0;
  logic spur_rd = 1'b0, spur_ca = 1'b0, spur_wr = 1'b0;

  assign rd_done    = (rd_req    && cnt_rd == lat_rd) || spur_rd;
  assign shift_done = (shift_req && cnt_sh == lat_sh);
  assign calc_done  = (calc_req  && cnt_ca == lat_ca) || spur_ca;
  assign wr_done    = (wr_req    && cnt_wr == lat_wr) || spur_wr;

  always @(posedge clk) begin
    cnt_rd <= (rd_req    && !rd_done)    ? cnt_rd + 1 : 0;
    cnt_sh <= (shift_req && !shift_done) ? cnt_sh + 1 : 0;
    cnt_ca <= (calc_req  && !calc_done)  ? cnt_ca + 1 : 0;
    cnt_wr <= (wr_req    && !wr_done)    ? cnt_wr + 1 : 0;
  end

  // Transaction monitor, sampled on the falling edge.
  int rd_n, sh_n, ca_n, wr_n, clr_n, done_n, hold_err;
  logic [AW-1:0] rd_log[$];
  logic [AW-1:0] wr_log[$];
  bit   mon_en = 1'b0;
  logic p_rd, p_rdd, p_sh, p_shd, p_ca, p_cad, p_wr, p_wrd;

  initial begin
    rd_n = 0; sh_n = 0; ca_n = 0; wr_n = 0; clr_n = 0; done_n = 0; hold_err = 0;
    p_rd = 0; p_rdd = 0; p_sh = 0; p_shd = 0; p_ca = 0; p_cad = 0; p_wr = 0; p_wrd = 0;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (p_rd && !p_rdd && !rd_req)                  hold_err++;
      if (p_rd &&  p_rdd && (rd_n % 3 == 0) && rd_req) hold_err++;
      if (p_sh && !p_shd && !shift_req) hold_err++;
      if (p_sh &&  p_shd &&  shift_req) hold_err++;
      if (p_ca && !p_cad && !calc_req)  hold_err++;
      if (p_ca &&  p_cad &&  calc_req)  hold_err++;
      if (p_wr && !p_wrd && !wr_req)    hold_err++;
      if (p_wr &&  p_wrd &&  wr_req)    hold_err++;
    end
    if (rd_req && rd_done) begin rd_n++; rd_log.push_back(rd_addr); end
    if (shift_req && shift_done) sh_n++;
    if (calc_req && calc_done)   ca_n++;
    if (wr_req && wr_done) begin wr_n++; wr_log.push_back(wr_addr); end
    if (line_clr) clr_n++;
    if (done)     done_n++;
    p_rd = rd_req;    p_rdd = rd_done;
    p_sh = shift_req; p_shd = shift_done;
    p_ca = calc_req;  p_cad = calc_done;
    p_wr = wr_req;    p_wrd = wr_done;
  end

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    @(posedge clk); #1;
    rd_n = 0; sh_n = 0; ca_n = 0; wr_n = 0; clr_n = 0; done_n = 0; hold_err = 0;
    rd_log.delete();
    wr_log.delete();
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // sel: 0 done, 1 shift_req, 2 rd_req, 3 third write in progress.
  task automatic wait_for(input int sel, input int budget, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      case (sel)
        0: found = done;
        1: found = shift_req;
        2: found = rd_req;
        default: found = wr_req && (wr_n == 2);
      endcase
      if (found) break;
    end
    check(tag, found, 1);
  endtask

  int exp_rd1 [15] = '{0, 4, 8, 1, 5, 9, 2, 6, 10, 3, 7, 11, 4, 8, 12};
  int exp_wr  [4]  = '{5, 6, 9, 10};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    rst = 1'b1; start = 1'b0; abort = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_req", rd_req, 0);
    check("rst_shift_req", shift_req, 0);
    check("rst_calc_req", calc_req, 0);
    check("rst_wr_req", wr_req, 0);
    check("rst_line_clr", line_clr, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_wr_addr", wr_addr, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Frame 1: zero-latency responders, start latency, start-while-busy
    clear_counts();
    @(posedge clk); #1 start = 1'b1;
    @(negedge clk);
    check("lat_clr_before", line_clr, 0);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("lat_clr_n1", line_clr, 1);
    check("lat_busy_n1", busy, 1);
    check("lat_rd_n1", rd_req, 0);
    @(negedge clk);
    check("lat_rd_n2", rd_req, 1);
    check("lat_clr_n2", line_clr, 0);
    check("lat_addr_n2", rd_addr, 0);
    pulse_start();
    wait_for(0, 500, "f1_done_timeout");
    @(negedge clk);
    check("f1_done_pulse", done, 0);
    check("f1_busy_after", busy, 0);
    repeat (3) @(negedge clk);
    check("f1_reads", rd_n, 24);
    check("f1_shifts", sh_n, 8);
    check("f1_calcs", ca_n, 4);
    check("f1_writes", wr_n, 4);
    check("f1_line_clr", clr_n, 2);
    check("f1_done_cnt", done_n, 1);
    for (int i = 0; i < 15; i++) check($sformatf("f1_rd_addr[%0d]", i), rd_log[i], exp_rd1[i]);
    for (int i = 0; i < 4; i++)  check($sformatf("f1_wr_addr[%0d]", i), wr_log[i], exp_wr[i]);

    // Frame 2: every done delayed by 3 cycles, handshake hold checks
    lat_rd = 3; lat_sh = 3; lat_ca = 3; lat_wr = 3;
    clear_counts();
    mon_en = 1'b1;
    pulse_start();
    wait_for(0, 1000, "f2_done_timeout");
    @(negedge clk);
    mon_en = 1'b0;
    check("f2_reads", rd_n, 24);
    check("f2_shifts", sh_n, 8);
    check("f2_calcs", ca_n, 4);
    check("f2_writes", wr_n, 4);
    check("f2_done_cnt", done_n, 1);
    check("f2_hold_errors", hold_err, 0);
    idx = 0;
    for (int r = 1; r <= H - 2; r++)
      for (int c = 0; c < W; c++)
        for (int k = 0; k < 3; k++) begin
          check($sformatf("f2_rd_addr[%0d]", idx), rd_log[idx], (r - 1) * W + k * W + c);
          idx++;
        end

    // Spurious done strobes in IDLE and in SHIFT
    lat_rd = 0; lat_sh = 6; lat_ca = 0; lat_wr = 0;
    @(posedge clk); #1 spur_rd = 1'b1; spur_ca = 1'b1;
    @(negedge clk);
    check("spur_idle_busy", busy, 0);
    check("spur_idle_rd_req", rd_req, 0);
    check("spur_idle_calc_req", calc_req, 0);
    @(posedge clk); #1 spur_rd = 1'b0; spur_ca = 1'b0;
    @(negedge clk);
    check("spur_idle_busy2", busy, 0);
    clear_counts();
    pulse_start();
    wait_for(1, 100, "spur_shift_timeout");
    @(posedge clk); #1 spur_rd = 1'b1; spur_ca = 1'b1;
    @(negedge clk);
    check("spur_shift_hold", shift_req, 1);
    check("spur_shift_rd_req", rd_req, 0);
    check("spur_shift_calc_req", calc_req, 0);
    @(posedge clk); #1 spur_rd = 1'b0; spur_ca = 1'b0;
    @(negedge clk);
    check("spur_shift_hold2", shift_req, 1);
    wait_for(0, 1000, "f3_done_timeout");
    repeat (2) @(negedge clk);
    check("f3_reads", rd_n, 24);
    check("f3_shifts", sh_n, 8);
    check("f3_calcs", ca_n, 4);
    check("f3_rd_addr3", rd_log[3], 1);
    check("f3_rd_addr5", rd_log[5], 9);
    check("f3_wr_addr0", wr_log[0], 5);

    // Abort during third WRITE together with wr_done
    lat_sh = 0; lat_wr = 10;
    clear_counts();
    pulse_start();
    wait_for(3, 1000, "abort_wr3_timeout");
    @(posedge clk); #1 abort = 1'b1; spur_wr = 1'b1;
    @(posedge clk); #1 abort = 1'b0; spur_wr = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_wr_req", wr_req, 0);
    check("abort_done", done, 0);
    check("abort_rd_addr", rd_addr, 0);
    repeat (3) @(negedge clk);
    check("abort_no_done", done_n, 0);
    check("abort_idle", busy, 0);
    lat_wr = 0;
    clear_counts();
    pulse_start();
    @(negedge clk);
    check("restart_clr", line_clr, 1);
    @(negedge clk);
    check("restart_rd_req", rd_req, 1);
    check("restart_rd_addr", rd_addr, 0);
    wait_for(0, 500, "f4_done_timeout");
    repeat (2) @(negedge clk);
    check("f4_reads", rd_n, 24);
    check("f4_done_cnt", done_n, 1);

    // Asynchronous reset mid-READ
    lat_rd = 5;
    clear_counts();
    pulse_start();
    wait_for(2, 100, "rst_rd_timeout");
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check("arst_rd_req", rd_req, 0);
    check("arst_busy", busy, 0);
    check("arst_line_clr", line_clr, 0);
    check("arst_rd_addr", rd_addr, 0);
    check("arst_done", done, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("arst_idle", busy, 0);
    check("arst_no_done", done_n, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
